// File: rtl/shift_pkg.sv
// Shared definitions for the shift arbiter slice.
//   - Shift operation encodings driven on reqN_op / op.
//   - Port identifiers used for the round-robin pointer and result tag.
package shift_pkg;

    localparam logic [1:0] OP_LSL = 2'b00;  // logical left, zero-fill at LSB
    localparam logic [1:0] OP_LSR = 2'b01;  // logical right, zero-fill at MSB
    localparam logic [1:0] OP_ASR = 2'b10;  // arithmetic right, sign-fill
    localparam logic [1:0] OP_ROR = 2'b11;  // rotate right

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/shift_core_16bit.sv
// Combinational 16-bit shifter built from four constant-distance stages
// (8, 4, 2, 1). Each stage either passes its input or applies the selected
// op by its fixed distance, controlled by one bit of amt.
// Ports:
//   in  [15:0]  operand
//   amt [3:0]   shift amount 0..15
//   op  [1:0]   OP_LSL / OP_LSR / OP_ASR / OP_ROR
//   out [15:0]  shifted result
module shift_core_16bit
    import shift_pkg::*;
(
    input  logic [15:0] in,
    input  logic [3:0]  amt,
    input  logic [1:0]  op,
    output logic [15:0] out
);

    logic [15:0] stage [0:4];

    assign stage[0] = in;

    for (genvar gi = 0; gi < 4; gi++) begin : gen_stage
        localparam int SH = 8 >> gi;
        logic [15:0] shifted;

        // ASR stays correct across stages: the MSB of every intermediate
        // value is still the original sign bit, so sign-fill composes.
        always_comb begin
            case (op)
                OP_LSL:  shifted = stage[gi] << SH;
                OP_LSR:  shifted = stage[gi] >> SH;
                OP_ASR:  shifted = $signed(stage[gi]) >>> SH;
                default: shifted = (stage[gi] >> SH) | (stage[gi] << (16 - SH));
            endcase
        end

        assign stage[gi+1] = amt[3-gi] ? shifted : stage[gi];
    end

    assign out = stage[4];

endmodule

// File: rtl/shift_unit_arbiter.sv
// Two-port round-robin arbiter in front of one shared 16-bit shifter, with a
// one-entry registered result buffer tagged by the issuing port.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   reqN_valid/ready/data/amt/op   request port N (N = 0, 1), valid/ready
//   res_valid/ready/data/id        result buffer, valid/ready, port tag
// A result appears one cycle after its request fires. The buffer can be
// reloaded in the same cycle it is consumed, giving one result per cycle.
module shift_unit_arbiter
    import shift_pkg::*;
#(
    parameter int WIDTH     = 16,
    parameter int SHW       = 4,
    parameter int PRIO_INIT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_data,
    input  logic [SHW-1:0]   req0_amt,
    input  logic [1:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_data,
    input  logic [SHW-1:0]   req1_amt,
    input  logic [1:0]       req1_op,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_id
);

    logic             rr_ptr_reg, rr_ptr_next;
    logic             res_valid_reg, res_valid_next;
    logic [WIDTH-1:0] res_data_reg, res_data_next;
    logic             res_id_reg, res_id_next;

    logic             can_load;
    logic             grant0, grant1;
    logic             fire0, fire1;
    logic [WIDTH-1:0] mux_data;
    logic [SHW-1:0]   mux_amt;
    logic [1:0]       mux_op;
    logic [WIDTH-1:0] shift_out;

    // Buffer accepts a new result when empty or being drained this cycle.
    assign can_load = !res_valid_reg || res_ready;

    // A lone requester always wins; on contention rr_ptr picks the winner.
    assign grant0 = req0_valid && (!req1_valid || rr_ptr_reg == PORT0);
    assign grant1 = req1_valid && (!req0_valid || rr_ptr_reg == PORT1);

    assign req0_ready = !rst && can_load && grant0;
    assign req1_ready = !rst && can_load && grant1;

    assign fire0 = req0_valid && req0_ready;
    assign fire1 = req1_valid && req1_ready;

    // grant0/grant1 are mutually exclusive, so grant1 alone selects the operand.
    assign mux_data = grant1 ? req1_data : req0_data;
    assign mux_amt  = grant1 ? req1_amt  : req0_amt;
    assign mux_op   = grant1 ? req1_op   : req0_op;

    shift_core_16bit u_core (
        .in  (mux_data),
        .amt (mux_amt),
        .op  (mux_op),
        .out (shift_out)
    );

    always_comb begin
        rr_ptr_next    = rr_ptr_reg;
        res_valid_next = res_valid_reg;
        res_data_next  = res_data_reg;
        res_id_next    = res_id_reg;
        if (fire0 || fire1) begin
            res_data_next  = shift_out;
            res_id_next    = fire1 ? PORT1 : PORT0;
            res_valid_next = 1'b1;
            // Hand priority to the port that did not just win.
            rr_ptr_next    = fire1 ? PORT0 : PORT1;
        end else if (res_ready) begin
            res_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr_reg    <= 1'(PRIO_INIT);
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_id_reg    <= 1'b0;
        end else begin
            rr_ptr_reg    <= rr_ptr_next;
            res_valid_reg <= res_valid_next;
            res_data_reg  <= res_data_next;
            res_id_reg    <= res_id_next;
        end
    end

    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_id    = res_id_reg;

endmodule

// File: tb/tb_shift_unit_arbiter.sv
// Self-checking bench for shift_unit_arbiter: directed op/boundary tables,
// round-robin, backpressure, reset-in-stall and a randomized run, all checked
// against a behavioural model of the arbiter and shifter kept here.
module tb_shift_unit_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready;
    logic [15:0] req0_data;
    logic [3:0]  req0_amt;
    logic [1:0]  req0_op;
    logic        req1_valid, req1_ready;
    logic [15:0] req1_data;
    logic [3:0]  req1_amt;
    logic [1:0]  req1_op;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        res_id;

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    logic        m_valid;
    logic [15:0] m_data;
    logic        m_id;
    int          m_prio;

    always #5 clk = ~clk;

    shift_unit_arbiter #(.WIDTH(16), .SHW(4), .PRIO_INIT(0)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req0_amt(req0_amt), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .req1_amt(req1_amt), .req1_op(req1_op),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_id(res_id)
    );

    // Reference shifter using plain wide arithmetic.
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input logic [3:0] a,
                                              input logic [1:0] op);
        logic [31:0] w;
        int s;
        case (op)
            2'd0: w = {16'h0, d} << a;
            2'd1: w = {16'h0, d} >> a;
            2'd2: begin s = int'({{16{d[15]}}, d}); s = s >>> a; w = 32'(s); end
            default: w = ({16'h0, d} >> a) | ({16'h0, d} << (16 - int'(a)));
        endcase
        return w[15:0];
    endfunction

    // Which port the model accepts this cycle: -1 for none.
    function automatic int model_winner();
        if (rst) return -1;
        if (m_valid && !res_ready) return -1;
        if (req0_valid && req1_valid) return m_prio;
        if (req0_valid) return 0;
        if (req1_valid) return 1;
        return -1;
    endfunction

    // Advance the model by one clock edge with the inputs currently applied,
    // then let the DUT take the same edge.
    task automatic advance();
        int w;
        w = model_winner();
        if (rst) begin
            m_valid = 1'b0; m_data = 16'h0; m_id = 1'b0; m_prio = 0;
        end else if (w == 0) begin
            m_data = ref_shift(req0_data, req0_amt, req0_op);
            m_id = 1'b0; m_valid = 1'b1; m_prio = 1;
            $display("txn port=0 data=%h amt=%0d op=%0d -> %h", req0_data, req0_amt, req0_op, m_data);
        end else if (w == 1) begin
            m_data = ref_shift(req1_data, req1_amt, req1_op);
            m_id = 1'b1; m_valid = 1'b1; m_prio = 0;
            $display("txn port=1 data=%h amt=%0d op=%0d -> %h", req1_data, req1_amt, req1_op, m_data);
        end else if (res_ready) begin
            m_valid = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; res_ready = 1'b0;
        req0_valid = 1'b1; req0_data = 16'h1111; req0_amt = 4'd1; req0_op = 2'd0;
        req1_valid = 1'b1; req1_data = 16'h2222; req1_amt = 4'd2; req1_op = 2'd1;
        advance();
        @(negedge clk);
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            failures++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready);
        end
        checks++;
        if (res_valid !== 1'b0 || res_data !== 16'h0 || res_id !== 1'b0) begin
            failures++; $display("FAIL reset_state got v=%b d=%h id=%b exp v=0 d=0000 id=0", res_valid, res_data, res_id);
        end
        advance();
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
    endtask

    // Single-port directed table: first entry is the basic ASR case, then
    // the four ops at amt=4 and the amount boundaries.
    task automatic test_ops();
        logic [15:0] t_data [13];
        logic [3:0]  t_amt  [13];
        logic [1:0]  t_op   [13];
        logic [15:0] t_exp  [13];
        t_data = '{16'h8001, 16'h1234, 16'h1234, 16'hF234, 16'h1234, 16'h8000, 16'h0001,
                   16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'h8001, 16'h8001};
        t_amt  = '{4'd1, 4'd4, 4'd4, 4'd4, 4'd4, 4'd15, 4'd15, 4'd0, 4'd0, 4'd0, 4'd0, 4'd15, 4'd15};
        t_op   = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1};
        t_exp  = '{16'hC000, 16'h2340, 16'h0123, 16'hFF23, 16'h4123, 16'hFFFF, 16'h8000,
                   16'hA5A5, 16'hA5A5, 16'hA5A5, 16'hA5A5, 16'h0003, 16'h0001};
        res_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            req0_valid = 1'b1; req0_data = t_data[i]; req0_amt = t_amt[i]; req0_op = t_op[i];
            @(negedge clk);
            checks++;
            if (req0_ready !== 1'b1) begin
                failures++; $display("FAIL ops_ready[%0d] got=%b exp=1", i, req0_ready);
            end
            advance();
            req0_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (res_valid !== 1'b1 || res_data !== t_exp[i] || res_id !== 1'b0) begin
                failures++;
                $display("FAIL ops[%0d] got v=%b d=%h id=%b exp v=1 d=%h id=0", i, res_valid, res_data, res_id, t_exp[i]);
            end
        end
        advance();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            failures++; $display("FAIL ops_drain got=%b exp=0", res_valid);
        end
    endtask

    task automatic test_round_robin();
        logic [15:0] exp_d [6];
        rst = 1'b1; advance(); rst = 1'b0;
        res_ready = 1'b1;
        req0_valid = 1'b1; req1_valid = 1'b1;
        req0_data = 16'($urandom); req0_amt = 4'($urandom); req0_op = 2'($urandom);
        req1_data = 16'($urandom); req1_amt = 4'($urandom); req1_op = 2'($urandom);
        for (int i = 0; i <= 6; i++) begin
            if (i == 6) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end else if (i > 0 && (i - 1) % 2 == 0) begin
                req0_data = 16'($urandom); req0_amt = 4'($urandom); req0_op = 2'($urandom);
            end else if (i > 0) begin
                req1_data = 16'($urandom); req1_amt = 4'($urandom); req1_op = 2'($urandom);
            end
            @(negedge clk);
            if (i > 0) begin
                checks++;
                if (res_valid !== 1'b1 || res_id !== 1'((i - 1) % 2) || res_data !== exp_d[i-1]) begin
                    failures++;
                    $display("FAIL rr_result[%0d] got v=%b id=%b d=%h exp v=1 id=%0d d=%h",
                             i - 1, res_valid, res_id, res_data, (i - 1) % 2, exp_d[i-1]);
                end
            end
            if (i < 6) begin
                exp_d[i] = (i % 2 == 0) ? ref_shift(req0_data, req0_amt, req0_op)
                                        : ref_shift(req1_data, req1_amt, req1_op);
                checks++;
                if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                    failures++;
                    $display("FAIL rr_grant[%0d] got=%b%b exp port %0d", i, req0_ready, req1_ready, i % 2);
                end
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] held;
        req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
        req0_data = 16'h1234; req0_amt = 4'd4; req0_op = 2'd0;
        req1_data = 16'hF234; req1_amt = 4'd4; req1_op = 2'd2;
        advance();
        held = m_data;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                failures++; $display("FAIL bp_ready[%0d] got=%b%b exp=00", i, req0_ready, req1_ready);
            end
            checks++;
            if (res_valid !== 1'b1 || res_data !== held) begin
                failures++; $display("FAIL bp_stable[%0d] got v=%b d=%h exp v=1 d=%h", i, res_valid, res_data, held);
            end
            advance();
        end
        res_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ((req0_ready ^ req1_ready) !== 1'b1 || req0_ready !== (model_winner() == 0)) begin
            failures++; $display("FAIL bp_release got=%b%b exp winner %0d", req0_ready, req1_ready, model_winner());
        end
        advance();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_data !== m_data || res_id !== m_id) begin
            failures++;
            $display("FAIL bp_replace got v=%b d=%h id=%b exp v=1 d=%h id=%b", res_valid, res_data, res_id, m_data, m_id);
        end
    endtask

    task automatic test_reset_mid();
        res_ready = 1'b0; req0_valid = 1'b1; req1_valid = 1'b1;
        advance();
        rst = 1'b1;
        advance();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0) begin
            failures++; $display("FAIL rst_mid_valid got=%b exp=0", res_valid);
        end
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            failures++; $display("FAIL rst_mid_prio got=%b%b exp=10", req0_ready, req1_ready);
        end
        advance();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || res_id !== 1'b0 || res_data !== ref_shift(req0_data, req0_amt, req0_op)) begin
            failures++; $display("FAIL rst_mid_result got v=%b id=%b d=%h exp v=1 id=0", res_valid, res_id, res_data);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
        advance();
    endtask

    task automatic test_random();
        logic f0, f1;
        f0 = 1'b1; f1 = 1'b1;
        for (int i = 0; i < 250; i++) begin
            // A request that is pending and was not accepted must be held.
            if (!req0_valid || f0) begin
                req0_valid = ($urandom_range(0, 3) != 0);
                req0_data = 16'($urandom); req0_amt = 4'($urandom); req0_op = 2'($urandom);
            end
            if (!req1_valid || f1) begin
                req1_valid = ($urandom_range(0, 3) != 0);
                req1_data = 16'($urandom); req1_amt = 4'($urandom); req1_op = 2'($urandom);
            end
            res_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            f0 = (model_winner() == 0);
            f1 = (model_winner() == 1);
            checks++;
            if (req0_ready !== f0 || req1_ready !== f1) begin
                failures++; $display("FAIL rand_ready[%0d] got=%b%b exp=%b%b", i, req0_ready, req1_ready, f0, f1);
            end
            checks++;
            if (res_valid !== m_valid || (m_valid && (res_data !== m_data || res_id !== m_id))) begin
                failures++;
                $display("FAIL rand_res[%0d] got v=%b d=%h id=%b exp v=%b d=%h id=%b",
                         i, res_valid, res_data, res_id, m_valid, m_data, m_id);
            end
            advance();
        end
    endtask

    initial begin
        m_valid = 1'b0; m_data = 16'h0; m_id = 1'b0; m_prio = 0;
        #1;
        test_reset();
        test_ops();
        test_round_robin();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
